// File: rtl/vga_raster_timing.sv
`default_nettype none
// ============================================================================
// Module   : vga_raster_timing
// Brief    : Pixel-rate divider, raster scan counters, sync/blank decode and
//            frame-rate move strobe for the VGA display path.
// Revision : 1.0
// ============================================================================
module vga_raster_timing #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int MOVE_DIV  = 1
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pixpulse,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       hsync,
    output logic       vsync,
    output logic       blank,
    output logic       move
);

    localparam int c_H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0]  c_H_LAST     = 10'(c_H_TOTAL - 1);
    localparam logic [9:0]  c_V_LAST     = 10'(c_V_TOTAL - 1);
    localparam logic [9:0]  c_V_VBLANK   = 10'(V_VISIBLE);
    // Decode bounds are one bit wider so a sync end of exactly 1024 still compares correctly
    localparam logic [10:0] c_H_VIS      = 11'(H_VISIBLE);
    localparam logic [10:0] c_V_VIS      = 11'(V_VISIBLE);
    localparam logic [10:0] c_HS_START   = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] c_HS_END     = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] c_VS_START   = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] c_VS_END     = 11'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [7:0]  c_MOVE_LAST  = 8'(MOVE_DIV - 1);

    generate
        if (c_H_TOTAL > 1024) begin : g_bad_h_total
            $error("vga_raster_timing: horizontal total exceeds 1024");
        end
        if (c_V_TOTAL > 1024) begin : g_bad_v_total
            $error("vga_raster_timing: vertical total exceeds 1024");
        end
        if (MOVE_DIV < 1 || MOVE_DIV > 255) begin : g_bad_move_div
            $error("vga_raster_timing: MOVE_DIV must be 1..255");
        end
    endgenerate

    logic [1:0] r_div;
    logic       r_pixpulse;
    logic [9:0] r_hcount;
    logic [9:0] r_vcount;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_blank;
    logic       r_move;
    logic [7:0] r_frame_cnt;

    logic [9:0]  w_h_next;
    logic [9:0]  w_v_next;
    logic [10:0] w_h_ext;
    logic [10:0] w_v_ext;
    logic        w_vblank_entry;

    always_comb begin
        w_h_next = r_hcount + 10'd1;
        w_v_next = r_vcount;
        if (r_hcount == c_H_LAST) begin
            w_h_next = '0;
            w_v_next = (r_vcount == c_V_LAST) ? 10'd0 : r_vcount + 10'd1;
        end
        w_h_ext        = {1'b0, w_h_next};
        w_v_ext        = {1'b0, w_v_next};
        w_vblank_entry = (w_h_next == 10'd0) && (w_v_next == c_V_VBLANK);
    end

    // Decoded outputs are computed from the next scan position so they
    // change on the same edge as the counters they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div       <= '0;
            r_pixpulse  <= 1'b0;
            r_hcount    <= '0;
            r_vcount    <= '0;
            r_hsync     <= 1'b1;
            r_vsync     <= 1'b1;
            r_blank     <= 1'b0;
            r_move      <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_div      <= r_div + 2'd1;
            r_pixpulse <= (r_div == 2'd2);
            if (r_pixpulse) begin
                r_hcount <= w_h_next;
                r_vcount <= w_v_next;
                r_hsync  <= !((w_h_ext >= c_HS_START) && (w_h_ext < c_HS_END));
                r_vsync  <= !((w_v_ext >= c_VS_START) && (w_v_ext < c_VS_END));
                r_blank  <= (w_h_ext >= c_H_VIS) || (w_v_ext >= c_V_VIS);
                r_move   <= 1'b0;
                if (w_vblank_entry) begin
                    if (r_frame_cnt == c_MOVE_LAST) begin
                        r_frame_cnt <= '0;
                        r_move      <= 1'b1;
                    end else begin
                        r_frame_cnt <= r_frame_cnt + 8'd1;
                    end
                end
            end
        end
    end

    assign pixpulse = r_pixpulse;
    assign hcount   = r_hcount;
    assign vcount   = r_vcount;
    assign hsync    = r_hsync;
    assign vsync    = r_vsync;
    assign blank    = r_blank;
    assign move     = r_move;

endmodule
`default_nettype wire

// File: tb/tb_vga_raster_timing.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_raster_timing
// Brief    : Self-checking bench for vga_raster_timing on a reduced raster,
//            with MOVE_DIV=2 and MOVE_DIV=1 instances sharing clock/reset.
// Revision : 1.0
// ============================================================================
module tb_vga_raster_timing;

    localparam int HV = 8, HF = 2, HS = 3, HB = 2;
    localparam int VV = 4, VF = 1, VS = 2, VB = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME_PIX = HT * VT;
    localparam int FRAME_CLK = FRAME_PIX * 4;

    typedef struct {
        logic       pix;
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       bl;
        logic       mv2;
        logic       mv1;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       pixpulse, hsync, vsync, blank, move;
    logic [9:0] hcount, vcount;
    logic       pixpulse1, hsync1, vsync1, blank1, move1;
    logic [9:0] hcount1, vcount1;

    int   checks = 0;
    int   errors = 0;
    int   m      = 0;
    int   rises2 = 0;
    int   rises1 = 0;
    logic prev2  = 1'b0;
    logic prev1  = 1'b0;
    exp_t sb[$];
    exp_t cur;

    vga_raster_timing #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .MOVE_DIV(2)
    ) dut (
        .clk(clk), .rst(rst), .pixpulse(pixpulse), .hcount(hcount), .vcount(vcount),
        .hsync(hsync), .vsync(vsync), .blank(blank), .move(move)
    );

    vga_raster_timing #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .MOVE_DIV(1)
    ) dut1 (
        .clk(clk), .rst(rst), .pixpulse(pixpulse1), .hcount(hcount1), .vcount(vcount1),
        .hsync(hsync1), .vsync(vsync1), .blank(blank1), .move(move1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Closed-form reference: m edges since reset release -> p completed pixel periods
    function automatic exp_t model(input int mm);
        exp_t e;
        int   p, h, v, ent;
        p     = mm / 4;
        h     = p % HT;
        v     = (p / HT) % VT;
        e.pix = ((mm % 4) == 3);
        e.h   = 10'(h);
        e.v   = 10'(v);
        e.hs  = !((h >= HV + HF) && (h < HV + HF + HS));
        e.vs  = !((v >= VV + VF) && (v < VV + VF + VS));
        e.bl  = (h >= HV) || (v >= VV);
        ent   = ((p % FRAME_PIX) == VV * HT) ? (p / FRAME_PIX + 1) : 0;
        e.mv1 = (ent != 0);
        e.mv2 = (ent != 0) && ((ent % 2) == 0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at m=%0d", tag, obs, exp, m);
        end
    endtask

    task automatic step(input logic r);
        exp_t e;
        rst = r;
        @(posedge clk);
        m = r ? 0 : m + 1;
        sb.push_back(model(m));
        #1;
        e = sb.pop_front();
        cur = e;
        check("pixpulse", {9'b0, pixpulse}, {9'b0, e.pix});
        check("hcount",   hcount,           e.h);
        check("vcount",   vcount,           e.v);
        check("hsync",    {9'b0, hsync},    {9'b0, e.hs});
        check("vsync",    {9'b0, vsync},    {9'b0, e.vs});
        check("blank",    {9'b0, blank},    {9'b0, e.bl});
        check("move_div2", {9'b0, move},    {9'b0, e.mv2});
        check("move_div1", {9'b0, move1},   {9'b0, e.mv1});
        check("pixpulse1", {9'b0, pixpulse1}, {9'b0, e.pix});
        check("hcount1",  hcount1,          e.h);
        check("vcount1",  vcount1,          e.v);
        if (move && !prev2) rises2++;
        if (move1 && !prev1) rises1++;
        prev2 = move;
        prev1 = move1;
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1);

        // Four frames plus margin: vblank entries 1..4, move(div2) on 2 and 4
        for (int i = 0; i < 4 * FRAME_CLK + 20; i++) step(1'b0);
        check("move_div2_count", 10'(rises2), 10'd2);
        check("move_div1_count", 10'(rises1), 10'd4);

        // Land inside both sync pulses, then pulse reset for one clock
        begin
            int budget;
            budget = 2 * FRAME_CLK;
            while (!(cur.h == 10'(HV + HF + 1) && cur.v == 10'(VV + VF)) && budget > 0) begin
                step(1'b0);
                budget--;
            end
            check("reach_sync_point", 10'(budget > 0), 10'd1);
        end
        check("in_hsync", {9'b0, hsync}, 10'd0);
        check("in_vsync", {9'b0, vsync}, 10'd0);
        step(1'b1);
        check("rst_hsync", {9'b0, hsync}, 10'd1);
        check("rst_vsync", {9'b0, vsync}, 10'd1);
        check("rst_hcount", hcount, 10'd0);
        check("rst_vcount", vcount, 10'd0);

        for (int i = 0; i < 3 * FRAME_CLK; i++) step(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
